axi_slave_write_channel: RTL
============================

# axi_slave_write_channel

AXI write responder that terminates the write-address, write-data and write-response channels driven by our AXI write master. It accepts one burst at a time, turns each accepted data beat into a single-cycle write on a simple memory-side port, and returns a response when the burst ends. It sits between the AXI interconnect and on-chip memory or a peripheral register bank.

## Interface
- ADDR_WIDTH, 32, AXI byte-address width and memory-side address width
- WRITE_CHANNEL_WIDTH, 32, WDATA and memory data width
- WRITE_BURST_LEN, 8, AWLEN width; a burst carries AWLEN+1 beats

- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- AWVALID  in  1  address valid
- AWREADY  out  1  address ready
- AWADDR  in  ADDR_WIDTH  burst start byte address
- AWLEN  in  WRITE_BURST_LEN  beats minus one
- AWSIZE  in  3  bytes per beat = 2^AWSIZE
- AWBURST  in  2  0 = FIXED, 1 = INCR, 2/3 = INCR
- WVALID  in  1  data valid
- WREADY  out  1  data ready
- WDATA  in  WRITE_CHANNEL_WIDTH  beat data
- WLAST  in  1  last beat marker
- BVALID  out  1  response valid
- BREADY  in  1  response ready
- BRESP  out  1  1 = success, 0 = error
- mem_wready  in  1  memory can take a write this cycle
- mem_we  out  1  write strobe, one cycle per beat
- mem_waddr  out  ADDR_WIDTH  beat byte address
- mem_wdata  out  WRITE_CHANNEL_WIDTH  beat data
- done  out  1  one-cycle pulse after each response handshake

## Operation
- States: IDLE, DATA, RESP.
- IDLE: AWREADY=1. On AWVALID&&AWREADY, latch AWADDR as the current address, latch AWLEN, AWSIZE and AWBURST, clear the beat count and the error flag, then go to DATA.
- DATA: WREADY = mem_wready. A beat fires on WVALID&&WREADY.
  - mem_we = beat, mem_waddr = current address, mem_wdata = WDATA, all combinational from the beat.
  - The beat count increments on each beat.
  - INCR: the current address advances by 2^AWSIZE each beat, modulo 2^ADDR_WIDTH, with no error on wrap.
  - FIXED: the current address is held.
- The burst ends on the beat where count == AWLEN. With WLAST checking enabled, it also ends on any earlier beat carrying WLAST. Then go to RESP.
- RESP: BVALID=1 with BRESP = !error. On BVALID&&BREADY, go to IDLE and pulse done.
- No other inputs are looked at outside their own state. WVALID in IDLE or RESP is left pending, with WREADY=0.
- Only one burst is outstanding. AW is not accepted again until the B handshake completes.

## Timing
- While rst is high, and in the same cycle it asserts: state=IDLE, AWREADY=0 (gated by rst), WREADY=0, BVALID=0, BRESP=0, mem_we=0, mem_waddr=0, mem_wdata=0, done=0. Registers also clear to 0.
- rst asserted mid-burst aborts the burst. The partial burst gets no response, and no mem_we occurs after rst rises.
- AW handshake at cycle N → DATA at N+1. WREADY can be high at N+1, so the first beat can land at N+1.
- One beat per cycle at full rate when WVALID and mem_wready are both held high.
- Last beat at cycle M → BVALID=1 at M+1, held stable with its BRESP until BREADY.
- B handshake at cycle K → done=1 and AWREADY=1 at K+1, so the next AW can handshake at K+1.
- AWLEN=0: the single beat ends the burst regardless of the beat count arithmetic.
- AWLEN=2^WRITE_BURST_LEN-1: the count must not overflow before the compare.

## Configuration
- AXI_SLAVE_WLAST_CHECK_EN defined:
  - WLAST on beat i<AWLEN ends the burst early with BRESP=0.
  - WLAST low on beat AWLEN still ends the burst, with BRESP=0.
- Undefined: WLAST is ignored, the burst always ends at beat AWLEN, BRESP is always 1, and no error flag is built.

## Structure
- Shared package axi_pkg holds:
  - burst-type constants AXI_BURST_FIXED=0 and AXI_BURST_INCR=1;
  - response constants AXI_RESP_OK=1 and AXI_RESP_ERR=0, matching the master's success convention;
  - the slave state encoding.
- One natural sub-module, axi_burst_addr_gen: latches the start address, size and burst type and steps the current address on each beat. It can be reused later by the read-side slave.

## Test plan
- Single beat: AWADDR=0x100, AWLEN=0, AWSIZE=2, INCR, WDATA=0xDEADBEEF with WLAST → one mem_we, address 0x100, data 0xDEADBEEF; BVALID at the next cycle with BRESP=1; done one cycle after the B handshake.
- INCR burst: AWADDR=0x200, AWLEN=3, AWSIZE=2, continuous W → mem_waddr 0x200/0x204/0x208/0x20C on consecutive cycles, BRESP=1.
- Backpressure: mem_wready toggled 1,0,0,1 and BREADY delayed 3 cycles, 4-beat FIXED burst at 0x40 → four writes, all to 0x40, WREADY mirrors mem_wready, BVALID held stable for 3 cycles.
- WLAST error (macro on): AWLEN=3 with WLAST on beat 1 → 2 writes, BRESP=0. Same stimulus with the macro off → 4 writes, BRESP=1.
- Wrap and reset: AWADDR=0xFFFFFFFC, AWLEN=1, INCR → addresses 0xFFFFFFFC then 0x0. A second burst with rst pulsed after beat 1 → no further mem_we, no BVALID, AWREADY=1 after rst falls.

Source files
------------

// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI burst/response constants and write-slave state encoding
package axi_pkg;
  localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
  localparam logic       AXI_RESP_OK     = 1'b1;
  localparam logic       AXI_RESP_ERR    = 1'b0;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: latches burst start address/size/type and steps the beat address
// Ports: load_i latches start_addr_i/size_i/burst_i; step_i advances addr_o by 2^size
// (INCR, wraps modulo 2^ADDR_WIDTH) or holds it (FIXED).
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] start_addr_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  input  logic                  step_i,
  output logic [ADDR_WIDTH-1:0] addr_o
);
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            size_q;
  logic                  fixed_q;
  always_comb addr_d = load_i ? start_addr_i :
                       (step_i && !fixed_q) ? addr_q + (ADDR_WIDTH'(1) << size_q) : addr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      size_q  <= '0;
      fixed_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      if (load_i) begin
        size_q  <= size_i;
        fixed_q <= burst_i == AXI_BURST_FIXED;
      end
    end
  end
  assign addr_o = addr_q;
endmodule

// File: rtl/axi_slave_write_channel.sv
// axi_slave_write_channel: AXI write responder turning burst beats into single-cycle memory writes
// Ports: AW*/W*/B* AXI write channels; mem_wready/mem_we/mem_waddr/mem_wdata memory port;
// done pulses one cycle after each B handshake.
// Define AXI_SLAVE_WLAST_CHECK_EN to end bursts on WLAST and flag WLAST/AWLEN disagreement.
module axi_slave_write_channel
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH          = 32,
  parameter int WRITE_CHANNEL_WIDTH = 32,
  parameter int WRITE_BURST_LEN     = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [WRITE_BURST_LEN-1:0]     AWLEN,
  input  logic [2:0]                     AWSIZE,
  input  logic [1:0]                     AWBURST,
  input  logic                           WVALID,
  output logic                           WREADY,
  input  logic [WRITE_CHANNEL_WIDTH-1:0] WDATA,
  input  logic                           WLAST,
  output logic                           BVALID,
  input  logic                           BREADY,
  output logic                           BRESP,
  input  logic                           mem_wready,
  output logic                           mem_we,
  output logic [ADDR_WIDTH-1:0]          mem_waddr,
  output logic [WRITE_CHANNEL_WIDTH-1:0] mem_wdata,
  output logic                           done
);
  logic [1:0]                 state_q, state_d;
  logic [WRITE_BURST_LEN-1:0] len_q, len_d, cnt_q, cnt_d;
  logic                       done_q, aw_hs, beat, last, b_hs, resp_err, at_len;
  logic [ADDR_WIDTH-1:0]      cur_addr;
  assign AWREADY = !rst && state_q == ST_IDLE;
  assign WREADY  = !rst && state_q == ST_DATA && mem_wready;
  assign BVALID  = !rst && state_q == ST_RESP;
  assign aw_hs   = AWVALID && AWREADY;
  assign beat    = WVALID && WREADY;
  assign b_hs    = BVALID && BREADY;
  // Compare before incrementing so AWLEN at its maximum never sees a wrapped count.
  assign at_len  = cnt_q == len_q;
`ifdef AXI_SLAVE_WLAST_CHECK_EN
  logic err_q, err_d;
  assign last     = beat && (at_len || WLAST);
  assign resp_err = err_q;
  always_comb err_d = aw_hs ? 1'b0 : (beat && (WLAST != at_len)) ? 1'b1 : err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`else
  logic unused_wlast;
  assign unused_wlast = WLAST;
  assign last         = beat && at_len;
  assign resp_err     = 1'b0;
`endif
  assign BRESP     = BVALID && (resp_err ? AXI_RESP_ERR : AXI_RESP_OK);
  assign mem_we    = beat;
  assign mem_waddr = beat ? cur_addr : '0;
  assign mem_wdata = beat ? WDATA : '0;
  assign done      = !rst && done_q;
  always_comb begin
    state_d = aw_hs ? ST_DATA : last ? ST_RESP : b_hs ? ST_IDLE : state_q;
    len_d   = aw_hs ? AWLEN : len_q;
    cnt_d   = aw_hs ? '0 : beat ? cnt_q + WRITE_BURST_LEN'(1) : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      done_q  <= b_hs;
    end
  end
  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr (
    .clk          (clk),
    .rst          (rst),
    .load_i       (aw_hs),
    .start_addr_i (AWADDR),
    .size_i       (AWSIZE),
    .burst_i      (AWBURST),
    .step_i       (beat),
    .addr_o       (cur_addr)
  );
endmodule
